// File: rtl/digit_serial_adder.sv
// Digit-serial adder: a + b + cin, one R-bit digit per clock, LS digit first.
// Latency: done pulses N/R cycles after the start edge; busy high for N/R cycles.
// No backpressure: start is ignored while busy; sum/cout hold until next completion.
module digit_serial_adder #(
  parameter int N = 32,
  parameter int R = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout
);
  localparam int D  = N / R;
  localparam int CW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = (D > 1) ? N - R : 1;
  localparam logic [CW-1:0] LAST = CW'(D - 1);

  if (R < 1 || (N % R) != 0) begin : g_bad_width
    $error("digit_serial_adder: N must be an integer multiple of R");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  op_a, op_b;
  logic [PW-1:0] psum;
  logic          carry;
  logic [CW-1:0] cnt;
  logic [R:0]    dsum;
  logic [N-1:0]  res_nxt;
  logic          last_digit;
  logic          accept;

  assign dsum       = {1'b0, op_a[R-1:0]} + {1'b0, op_b[R-1:0]} + {{R{1'b0}}, carry};
  assign last_digit = (cnt == LAST);
  assign accept     = start && (state == IDLE || state == DONE);

  // Partial sum keeps only the digits already produced; the new digit lands on top.
  if (D > 1) begin : g_multi
    assign res_nxt = {dsum[R-1:0], psum};
  end else begin : g_single
    assign res_nxt = dsum[R-1:0];
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_digit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> R;
      op_b  <= op_b >> R;
      carry <= dsum[R];
      psum  <= res_nxt[N-1:N-PW];
      if (last_digit) begin
        sum  <= res_nxt;
        cout <= dsum[R];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
